// File: rtl/caxi4interconnect_slave_addr_arbiter_if.sv
// rtl/caxi4interconnect_slave_addr_arbiter_if.sv - address-channel arbitration bundle for one crossbar slave port
// master modport: arbiter side (drives the slave port address valid and grants)
// slave modport : requester/slave-port side (drives requests, slave ready, completions)
interface caxi4interconnect_slave_addr_arbiter_if #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int OPEN_TRANS_WIDTH  = 4
);
  logic [NUM_MASTERS-1:0]       masterReq;
  logic [NUM_MASTERS-1:0]       masterReady;
  logic                         slaveValid;
  logic                         slaveReady;
  logic [NUM_MASTERS_WIDTH-1:0] grantEnc;
  logic [NUM_MASTERS-1:0]       grantOneHot;
  logic                         txnDone;
  logic [OPEN_TRANS_WIDTH-1:0]  openCount;
  logic                         countErr;

  modport master (
    input  masterReq, slaveReady, txnDone,
    output masterReady, slaveValid, grantEnc, grantOneHot, openCount, countErr
  );

  modport slave (
    output masterReq, slaveReady, txnDone,
    input  masterReady, slaveValid, grantEnc, grantOneHot, openCount, countErr
  );
endinterface

// File: rtl/caxi4interconnect_slave_addr_arbiter.sv
// rtl/caxi4interconnect_slave_addr_arbiter.sv - round-robin AW/AR arbiter with outstanding-transaction throttle
// Optional macro CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN: master 0 preempts round-robin in IDLE;
// the pointer then rotates over masters 1..N-1 only and is not advanced by master 0 grants.
module caxi4interconnect_slave_addr_arbiter #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int OPEN_TRANS_MAX    = 8,
  parameter int OPEN_TRANS_WIDTH  = 4
) (
  input  logic sysClk,
  input  logic sysReset,
  caxi4interconnect_slave_addr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FULL  = 2'd2
  } arbStateT;

  localparam logic [OPEN_TRANS_WIDTH-1:0]  MAX_COUNT   = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
  localparam logic [NUM_MASTERS_WIDTH-1:0] LAST_MASTER = NUM_MASTERS_WIDTH'(NUM_MASTERS - 1);

  arbStateT                     state;
  arbStateT                     stateNext;
  logic [NUM_MASTERS_WIDTH-1:0] grantIdx;
  logic [NUM_MASTERS_WIDTH-1:0] rrPtr;
  logic [NUM_MASTERS_WIDTH-1:0] winnerIdx;
  logic [NUM_MASTERS_WIDTH-1:0] ptrAfterGrant;
  logic [NUM_MASTERS-1:0]       candReq;
  logic [NUM_MASTERS-1:0]       oneHot;
  logic                         winnerFound;
  logic                         validInt;
  logic                         handshake;
  logic                         arbitrate;
  logic [OPEN_TRANS_WIDTH-1:0]  openCnt;
  logic [OPEN_TRANS_WIDTH-1:0]  openCntNext;
  logic                         cntErr;

  // A registered grant is exactly the GRANT state; valid never depends on same-cycle requests.
  assign validInt  = (state == GRANT);
  assign handshake = validInt & bus.slaveReady;
  // Arbitrate only from IDLE with headroom; the handshake cycle is never an arbitration cycle.
  assign arbitrate = (state == IDLE) && (openCnt < MAX_COUNT) && winnerFound;

  // Winner search: first requester at or above the pointer, then wrap to the ones below it.
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candReq     = bus.masterReq;
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
    if (bus.masterReq[0]) begin
      winnerFound = 1'b1;
    end else begin
      candReq[0] = 1'b0;
    end
`endif
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!winnerFound && candReq[i] && (i >= int'(rrPtr))) begin
        winnerFound = 1'b1;
        winnerIdx   = NUM_MASTERS_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!winnerFound && candReq[i] && (i < int'(rrPtr))) begin
        winnerFound = 1'b1;
        winnerIdx   = NUM_MASTERS_WIDTH'(i);
      end
    end
  end

  // Pointer value to load on handshake: one past the served master, wrapping to 0.
  always_comb begin
    ptrAfterGrant = (grantIdx == LAST_MASTER) ? '0 : grantIdx + 1'b1;
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
    if (grantIdx == '0) begin
      ptrAfterGrant = rrPtr;
    end
`endif
  end

  // Outstanding count: a handshake and a completion in the same cycle cancel out; never below zero.
  always_comb begin
    openCntNext = openCnt;
    if (handshake && !bus.txnDone) begin
      openCntNext = openCnt + 1'b1;
    end else if (!handshake && bus.txnDone && (openCnt != '0)) begin
      openCntNext = openCnt - 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (arbitrate) stateNext = GRANT;
      GRANT:   if (handshake) stateNext = (openCntNext == MAX_COUNT) ? FULL : IDLE;
      FULL:    if (bus.txnDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Grant capture on arbitration; pointer rotation on handshake.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      grantIdx <= '0;
      rrPtr    <= '0;
    end else begin
      if (arbitrate) begin
        grantIdx <= winnerIdx;
      end
      if (handshake) begin
        rrPtr <= ptrAfterGrant;
      end
    end
  end

  // Outstanding counter and sticky underflow flag.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      openCnt <= '0;
      cntErr  <= 1'b0;
    end else begin
      openCnt <= openCntNext;
      if (bus.txnDone && (openCnt == '0)) begin
        cntErr <= 1'b1;
      end
    end
  end

  assign oneHot          = validInt ? (NUM_MASTERS'(1) << grantIdx) : '0;
  assign bus.slaveValid  = validInt;
  assign bus.grantEnc    = grantIdx;
  assign bus.grantOneHot = oneHot;
  assign bus.masterReady = oneHot & {NUM_MASTERS{bus.slaveReady}};
  assign bus.openCount   = openCnt;
  assign bus.countErr    = cntErr;

endmodule

// File: tb/tb_caxi4interconnect_slave_addr_arbiter.sv
// tb/tb_caxi4interconnect_slave_addr_arbiter.sv - scenario and randomized checks of the slave address arbiter
`timescale 1ns/1ps
module tb_caxi4interconnect_slave_addr_arbiter;
  localparam int NM   = 4;
  localparam int NMW  = 2;
  localparam int MAXT = 8;
  localparam int OTW  = 4;
  localparam int SMAX = 2;
  localparam int SOTW = 2;

  logic sysClk = 1'b0;
  logic sysReset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 sysClk = ~sysClk;

  caxi4interconnect_slave_addr_arbiter_if #(.NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .OPEN_TRANS_WIDTH(OTW))  bus ();
  caxi4interconnect_slave_addr_arbiter_if #(.NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .OPEN_TRANS_WIDTH(SOTW)) busSmall ();

  caxi4interconnect_slave_addr_arbiter #(
    .NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .OPEN_TRANS_MAX(MAXT), .OPEN_TRANS_WIDTH(OTW)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset), .bus(bus)
  );

  caxi4interconnect_slave_addr_arbiter #(
    .NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .OPEN_TRANS_MAX(SMAX), .OPEN_TRANS_WIDTH(SOTW)
  ) dutSmall (
    .sysClk(sysClk), .sysReset(sysReset), .bus(busSmall)
  );

  // Reference model of the main instance: is an address offered, to whom, rotation start, outstanding count, error.
  bit mValid = 1'b0;
  int mIdx   = 0;
  int mPtr   = 0;
  int mCount = 0;
  bit mErr   = 1'b0;

  function automatic int pickWinner(input logic [NM-1:0] req, input int ptr);
    int c;
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
    if (req[0]) return 0;
    for (int k = 0; k < NM; k++) begin
      c = (ptr + k) % NM;
      if (c != 0 && req[c]) return c;
    end
`else
    for (int k = 0; k < NM; k++) begin
      c = (ptr + k) % NM;
      if (req[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic modelStep();
    bit hs;
    int newCount;
    if (sysReset) begin
      mValid = 1'b0; mIdx = 0; mPtr = 0; mCount = 0; mErr = 1'b0;
    end else begin
      hs = mValid && bus.slaveReady;
      newCount = mCount;
      if (hs && !bus.txnDone) newCount = mCount + 1;
      if (!hs && bus.txnDone && mCount > 0) newCount = mCount - 1;
      if (bus.txnDone && mCount == 0) mErr = 1'b1;
      if (hs) begin
        mValid = 1'b0;
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
        if (mIdx != 0) mPtr = (mIdx + 1) % NM;
`else
        mPtr = (mIdx + 1) % NM;
`endif
      end else if (!mValid && mCount < MAXT && bus.masterReq != '0) begin
        mIdx   = pickWinner(bus.masterReq, mPtr);
        mValid = 1'b1;
      end
      mCount = newCount;
    end
  endtask

  function automatic logic [NM-1:0] modelOneHot();
    logic [NM-1:0] one;
    one = 1;
    return mValid ? (one << mIdx) : '0;
  endfunction

  task automatic advance();
    @(posedge sysClk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    sysReset = 1'b1;
    advance();
    sysReset = 1'b0;
  endtask

  task automatic test_reset();
    bus.masterReq = '0; bus.slaveReady = 1'b0; bus.txnDone = 1'b0;
    busSmall.masterReq = '0; busSmall.slaveReady = 1'b0; busSmall.txnDone = 1'b0;
    doReset();
    advance();
    doReset();
    #1;
    checks++; if (bus.slaveValid !== 1'b0) begin errors++; $display("FAIL reset slaveValid: got %b want 0", bus.slaveValid); end
    checks++; if (bus.grantEnc !== 2'd0) begin errors++; $display("FAIL reset grantEnc: got %0d want 0", bus.grantEnc); end
    checks++; if (bus.grantOneHot !== 4'b0000) begin errors++; $display("FAIL reset grantOneHot: got %b want 0000", bus.grantOneHot); end
    checks++; if (bus.masterReady !== 4'b0000) begin errors++; $display("FAIL reset masterReady: got %b want 0000", bus.masterReady); end
    checks++; if (bus.openCount !== 4'd0) begin errors++; $display("FAIL reset openCount: got %0d want 0", bus.openCount); end
    checks++; if (bus.countErr !== 1'b0) begin errors++; $display("FAIL reset countErr: got %b want 0", bus.countErr); end
    checks++; if (busSmall.slaveValid !== 1'b0 || busSmall.openCount !== 2'd0) begin
      errors++; $display("FAIL reset small: got valid=%b count=%0d want 0/0", busSmall.slaveValid, busSmall.openCount);
    end
  endtask

  task automatic test_round_robin();
    int seq [4];
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
    seq = '{0, 0, 0, 0};
`else
    seq = '{0, 2, 0, 2};
`endif
    doReset();
    bus.masterReq = 4'b0101; bus.slaveReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus.slaveValid !== ((c % 2) == 1)) begin
        errors++; $display("FAIL rr slaveValid cyc %0d: got %b want %b", c, bus.slaveValid, (c % 2) == 1);
      end
      if ((c % 2) == 1) begin
        checks++; if (bus.masterReady !== (4'b0001 << seq[c / 2]) || bus.grantEnc !== 2'(seq[c / 2])) begin
          errors++; $display("FAIL rr grant %0d: got ready=%b enc=%0d want master %0d", c / 2, bus.masterReady, bus.grantEnc, seq[c / 2]);
        end
      end
      advance();
    end
    checks++; if (bus.openCount !== 4'd4) begin errors++; $display("FAIL rr openCount: got %0d want 4", bus.openCount); end
  endtask

  task automatic test_hold();
    bus.masterReq = 4'b1000; bus.slaveReady = 1'b0; bus.txnDone = 1'b0;
    #1;
    checks++; if (bus.slaveValid !== 1'b0) begin errors++; $display("FAIL hold pre-valid: got %b want 0", bus.slaveValid); end
    advance();
    bus.masterReq = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.slaveValid !== 1'b1 || bus.grantEnc !== 2'd3 || bus.grantOneHot !== 4'b1000) begin
        errors++; $display("FAIL hold stable cyc %0d: got valid=%b enc=%0d onehot=%b want 1/3/1000", c, bus.slaveValid, bus.grantEnc, bus.grantOneHot);
      end
      checks++; if (bus.masterReady !== 4'b0000) begin errors++; $display("FAIL hold ready cyc %0d: got %b want 0000", c, bus.masterReady); end
      advance();
    end
    bus.slaveReady = 1'b1; bus.masterReq = 4'b1000;
    #1;
    checks++; if (bus.masterReady !== 4'b1000) begin errors++; $display("FAIL hold handshake ready: got %b want 1000", bus.masterReady); end
    advance();
    bus.slaveReady = 1'b0; bus.masterReq = '0;
    #1;
    checks++; if (bus.slaveValid !== 1'b0 || bus.masterReady !== 4'b0000) begin
      errors++; $display("FAIL hold release: got valid=%b ready=%b want 0/0000", bus.slaveValid, bus.masterReady);
    end
    checks++; if (bus.openCount !== 4'd5) begin errors++; $display("FAIL hold openCount: got %0d want 5", bus.openCount); end
  endtask

  task automatic test_throttle();
    int hsCount;
    bus.masterReq = '0; bus.slaveReady = 1'b0; bus.txnDone = 1'b0;
    doReset();
    busSmall.masterReq = 4'b1111; busSmall.slaveReady = 1'b1; busSmall.txnDone = 1'b0;
    hsCount = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (busSmall.masterReady != '0) hsCount++;
      advance();
    end
    checks++; if (hsCount !== 2) begin errors++; $display("FAIL throttle handshakes: got %0d want 2", hsCount); end
    checks++; if (busSmall.slaveValid !== 1'b0 || busSmall.openCount !== 2'd2) begin
      errors++; $display("FAIL throttle full: got valid=%b count=%0d want 0/2", busSmall.slaveValid, busSmall.openCount);
    end
    busSmall.txnDone = 1'b1;
    advance();
    busSmall.txnDone = 1'b0;
    #1;
    checks++; if (busSmall.slaveValid !== 1'b0) begin errors++; $display("FAIL throttle gap: got valid=%b want 0", busSmall.slaveValid); end
    advance();
    hsCount = 0;
    #1;
    checks++; if (busSmall.slaveValid !== 1'b1) begin errors++; $display("FAIL throttle regrant: got valid=%b want 1", busSmall.slaveValid); end
    for (int c = 0; c < 6; c++) begin
      #1;
      if (busSmall.masterReady != '0) hsCount++;
      advance();
    end
    checks++; if (hsCount !== 1 || busSmall.openCount !== 2'd2) begin
      errors++; $display("FAIL throttle after done: got hs=%0d count=%0d want 1/2", hsCount, busSmall.openCount);
    end
    busSmall.masterReq = '0; busSmall.slaveReady = 1'b0;
  endtask

  task automatic test_count();
    doReset();
    bus.masterReq = 4'b0001; bus.slaveReady = 1'b1; bus.txnDone = 1'b0;
    advance();
    advance();
    bus.slaveReady = 1'b0;
    advance();
    bus.slaveReady = 1'b1; bus.txnDone = 1'b1;
    #1;
    checks++; if (bus.masterReady !== 4'b0001) begin errors++; $display("FAIL count hs ready: got %b want 0001", bus.masterReady); end
    advance();
    bus.masterReq = '0; bus.slaveReady = 1'b0;
    #1;
    checks++; if (bus.openCount !== 4'd1 || bus.countErr !== 1'b0) begin
      errors++; $display("FAIL count hs+done: got count=%0d err=%b want 1/0", bus.openCount, bus.countErr);
    end
    advance();
    #1;
    checks++; if (bus.openCount !== 4'd0 || bus.countErr !== 1'b0) begin
      errors++; $display("FAIL count done: got count=%0d err=%b want 0/0", bus.openCount, bus.countErr);
    end
    advance();
    bus.txnDone = 1'b0;
    #1;
    checks++; if (bus.openCount !== 4'd0 || bus.countErr !== 1'b1) begin
      errors++; $display("FAIL count underflow: got count=%0d err=%b want 0/1", bus.openCount, bus.countErr);
    end
    advance();
    checks++; if (bus.countErr !== 1'b1) begin errors++; $display("FAIL count sticky: got %b want 1", bus.countErr); end
  endtask

  task automatic test_reset_mid();
    bus.masterReq = 4'b0010; bus.slaveReady = 1'b1; bus.txnDone = 1'b0;
    advance();
    advance();
    bus.masterReq = 4'b1000; bus.slaveReady = 1'b0;
    advance();
    checks++; if (bus.slaveValid !== 1'b1 || bus.grantEnc !== 2'd3) begin
      errors++; $display("FAIL rstmid grant: got valid=%b enc=%0d want 1/3", bus.slaveValid, bus.grantEnc);
    end
    doReset();
    #1;
    checks++; if (bus.slaveValid !== 1'b0 || bus.openCount !== 4'd0 || bus.countErr !== 1'b0 || bus.grantOneHot !== 4'b0000) begin
      errors++; $display("FAIL rstmid state: got valid=%b count=%0d err=%b onehot=%b want 0/0/0/0000",
                         bus.slaveValid, bus.openCount, bus.countErr, bus.grantOneHot);
    end
    bus.masterReq = 4'b0110;
    advance();
    checks++; if (bus.slaveValid !== 1'b1 || bus.grantEnc !== 2'd1) begin
      errors++; $display("FAIL rstmid lowest: got valid=%b enc=%0d want 1/1", bus.slaveValid, bus.grantEnc);
    end
    bus.slaveReady = 1'b1; bus.masterReq = '0;
    advance();
    bus.slaveReady = 1'b0;
  endtask

`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
  task automatic test_priority();
    int seq [4];
    seq = '{1, 2, 1, 2};
    doReset();
    bus.masterReq = 4'b0111; bus.slaveReady = 1'b1; bus.txnDone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if ((c % 2) == 1) begin
        checks++; if (bus.masterReady !== 4'b0001) begin errors++; $display("FAIL prio m0 cyc %0d: got %b want 0001", c, bus.masterReady); end
      end
      advance();
    end
    bus.masterReq = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      #1;
      if ((c % 2) == 1) begin
        checks++; if (bus.masterReady !== (4'b0001 << seq[c / 2])) begin
          errors++; $display("FAIL prio rr %0d: got %b want master %0d", c / 2, bus.masterReady, seq[c / 2]);
        end
      end
      advance();
    end
    bus.masterReq = '0; bus.slaveReady = 1'b0;
  endtask
`endif

  task automatic test_random();
    doReset();
    for (int c = 0; c < 600; c++) begin
      sysReset       = ($urandom_range(0, 99) == 0);
      bus.masterReq  = NM'($urandom);
      bus.slaveReady = ($urandom_range(0, 2) != 0);
      bus.txnDone    = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (bus.slaveValid !== mValid) begin errors++; $display("FAIL rnd slaveValid cyc %0d: got %b want %b", c, bus.slaveValid, mValid); end
      checks++; if (bus.grantOneHot !== modelOneHot()) begin errors++; $display("FAIL rnd grantOneHot cyc %0d: got %b want %b", c, bus.grantOneHot, modelOneHot()); end
      checks++; if (bus.masterReady !== (bus.slaveReady ? modelOneHot() : 4'b0000)) begin
        errors++; $display("FAIL rnd masterReady cyc %0d: got %b want %b", c, bus.masterReady, bus.slaveReady ? modelOneHot() : 4'b0000);
      end
      checks++; if (bus.openCount !== OTW'(mCount)) begin errors++; $display("FAIL rnd openCount cyc %0d: got %0d want %0d", c, bus.openCount, mCount); end
      checks++; if (bus.countErr !== mErr) begin errors++; $display("FAIL rnd countErr cyc %0d: got %b want %b", c, bus.countErr, mErr); end
      if (mValid) begin
        checks++; if (bus.grantEnc !== NMW'(mIdx)) begin errors++; $display("FAIL rnd grantEnc cyc %0d: got %0d want %0d", c, bus.grantEnc, mIdx); end
      end
      advance();
    end
    sysReset = 1'b0;
    bus.masterReq = '0; bus.slaveReady = 1'b0; bus.txnDone = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_throttle();
    test_count();
    test_reset_mid();
`ifdef CAXI4INTERCONNECT_ARB_MASTER0_PRIORITY_EN
    test_priority();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
